// File: rtl/ex_pipe_if.sv
// ex_pipe_if: operand/result bundle for the ex_pipe execute stage.
// The master side (upstream and downstream logic) drives operands, flush and
// out_ready. The slave side (the execute stage) drives in_ready and all
// results.
interface ex_pipe_if #(
   parameter int XLEN = 32
);
   logic            flush;
   logic            in_valid;
   logic            in_ready;
   logic [XLEN-1:0] rs;
   logic [XLEN-1:0] rt;
   logic [XLEN-1:0] sign_ext;
   logic [XLEN-1:0] pc;
   logic            ALUSrc;
   logic [1:0]      ALUOp;
   logic [5:0]      funct;
   logic            branch;
   logic            out_valid;
   logic            out_ready;
   logic [XLEN-1:0] resultOut;
   logic [XLEN-1:0] address;
   logic [XLEN-1:0] pcout;
   logic [XLEN-1:0] offset;
   logic            zero;
   logic            take_branch;
   logic            busy;

   modport master (
      output flush, in_valid, rs, rt, sign_ext, pc, ALUSrc, ALUOp, funct,
             branch, out_ready,
      input  in_ready, out_valid, resultOut, address, pcout, offset, zero,
             take_branch, busy
   );

   modport slave (
      input  flush, in_valid, rs, rt, sign_ext, pc, ALUSrc, ALUOp, funct,
             branch, out_ready,
      output in_ready, out_valid, resultOut, address, pcout, offset, zero,
             take_branch, busy
   );
endinterface

// File: rtl/ex_pipe.sv
// ex_pipe: execute stage with a registered, back-pressured result.
// Computes ALU result, branch target, shifted offset and branch decision.
// Single-cycle ops appear one edge after acceptance. With EX_PIPE_MULT_EN
// defined, R-type mult runs on an iterative shift-add unit (XLEN busy
// cycles, then one DONE cycle that loads the output register). Without it,
// mult is treated as an unknown funct.
module ex_pipe #(
   parameter int XLEN = 32
) (
   input  logic     clk,
   input  logic     reset,
   ex_pipe_if.slave bus
);

   localparam logic [5:0] F_ADD  = 6'b100000;
   localparam logic [5:0] F_SUB  = 6'b100010;
   localparam logic [5:0] F_AND  = 6'b100100;
   localparam logic [5:0] F_OR   = 6'b100101;
   localparam logic [5:0] F_SLT  = 6'b101010;
`ifdef EX_PIPE_MULT_EN
   localparam logic [5:0] F_MULT = 6'b011000;
   localparam int         CNT_W  = $clog2(XLEN) + 1;
`endif

`ifdef EX_PIPE_MULT_EN
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MUL  = 2'd1,
      DONE = 2'd2
   } state_t;
`else
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      DONE = 2'd2
   } state_t;
`endif

   state_t state;
   state_t state_nxt;

   logic signed [XLEN-1:0] opa;
   logic signed [XLEN-1:0] opb;
   logic signed [XLEN-1:0] alu_res;
   logic signed [XLEN-1:0] offset_c;
   logic signed [XLEN-1:0] address_c;

   logic busy_c;
   logic in_ready_c;
   logic accept;
   logic mul_start;
   logic load_single;
   logic load_mul;

   logic signed [XLEN-1:0] res_p1;
   logic signed [XLEN-1:0] addr_p1;
   logic signed [XLEN-1:0] pc_p1;
   logic signed [XLEN-1:0] off_p1;
   logic                   zero_p1;
   logic                   tb_p1;
   logic                   vld_p1;

`ifdef EX_PIPE_MULT_EN
   logic signed [XLEN-1:0] mcand_p0;
   logic signed [XLEN-1:0] mplier_p0;
   logic signed [XLEN-1:0] acc_p0;
   logic signed [XLEN-1:0] pc_p0;
   logic signed [XLEN-1:0] off_p0;
   logic signed [XLEN-1:0] addr_p0;
   logic                   br_p0;
   logic [CNT_W-1:0]       cnt_p0;
`endif

   // Single-cycle ALU; mult is never decoded here, so it falls to result 0.
   function automatic logic signed [XLEN-1:0] alu_calc(
      input logic signed [XLEN-1:0] a,
      input logic signed [XLEN-1:0] b,
      input logic [1:0]             op,
      input logic [5:0]             fn
   );
      logic signed [XLEN-1:0] r;
      r = '0;
      case (op)
         2'b00: r = a + b;
         2'b01: r = a - b;
         2'b11: r[0] = (a < b);
         default: begin
            case (fn)
               F_ADD:   r = a + b;
               F_SUB:   r = a - b;
               F_AND:   r = a & b;
               F_OR:    r = a | b;
               F_SLT:   r[0] = (a < b);
               default: r = '0;
            endcase
         end
      endcase
      return r;
   endfunction

   assign opa       = bus.rs;
   assign opb       = bus.ALUSrc ? bus.sign_ext : bus.rt;
   assign alu_res   = alu_calc(opa, opb, bus.ALUOp, bus.funct);
   assign offset_c  = bus.sign_ext << 2;
   assign address_c = bus.pc + offset_c;

`ifdef EX_PIPE_MULT_EN
   assign busy_c    = (state == MUL);
`else
   assign busy_c    = 1'b0;
`endif

   // The DONE cycle also refuses input: the output register is reserved for the product.
   assign in_ready_c  = (!vld_p1 || bus.out_ready) && !busy_c && !bus.flush &&
                        (state != DONE);
   assign accept      = bus.in_valid && in_ready_c;

`ifdef EX_PIPE_MULT_EN
   assign mul_start   = accept && (bus.ALUOp == 2'b10) && (bus.funct == F_MULT);
   assign load_mul    = (state == DONE) && !bus.flush;
`else
   assign mul_start   = 1'b0;
   assign load_mul    = 1'b0;
`endif
   assign load_single = accept && !mul_start;

   // Control state register; reset abandons any multiply in flight.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_nxt;
   end

   // Next-state: flush wins over everything, DONE always returns to IDLE.
   always_comb begin
      state_nxt = state;
      if (bus.flush) begin
         state_nxt = IDLE;
      end else begin
         case (state)
`ifdef EX_PIPE_MULT_EN
            IDLE:    if (mul_start) state_nxt = MUL;
            MUL:     if (cnt_p0 == CNT_W'(XLEN - 1)) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
`else
            IDLE:    state_nxt = IDLE;
            DONE:    state_nxt = IDLE;
`endif
            default: state_nxt = IDLE;
         endcase
      end
   end

`ifdef EX_PIPE_MULT_EN
   // ---- stage p0: iterative multiply ----
   // Iteration counter: one shift-add step per MUL cycle.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)              cnt_p0 <= '0;
      else if (mul_start)      cnt_p0 <= '0;
      else if (state == MUL)   cnt_p0 <= cnt_p0 + 1'b1;
   end

   // Shift-add datapath; low XLEN bits of the product are the same for signed and unsigned.
   always_ff @(posedge clk) begin
      if (mul_start) begin
         mcand_p0  <= opa;
         mplier_p0 <= opb;
         acc_p0    <= '0;
         pc_p0     <= bus.pc;
         off_p0    <= offset_c;
         addr_p0   <= address_c;
         br_p0     <= bus.branch;
      end else if (state == MUL) begin
         if (mplier_p0[0]) acc_p0 <= acc_p0 + mcand_p0;
         mcand_p0  <= mcand_p0 <<< 1;
         mplier_p0 <= mplier_p0 >> 1;
      end
   end
`endif

   // ---- stage p1: output register ----
   // Output register: loads on accept or DONE, holds under back-pressure, clears on drain or flush.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         vld_p1  <= 1'b0;
         res_p1  <= '0;
         addr_p1 <= '0;
         pc_p1   <= '0;
         off_p1  <= '0;
         zero_p1 <= 1'b0;
         tb_p1   <= 1'b0;
      end else if (bus.flush) begin
         vld_p1  <= 1'b0;
      end else if (load_single) begin
         vld_p1  <= 1'b1;
         res_p1  <= alu_res;
         addr_p1 <= address_c;
         pc_p1   <= bus.pc;
         off_p1  <= offset_c;
         zero_p1 <= (alu_res == '0);
         tb_p1   <= bus.branch && (alu_res == '0);
`ifdef EX_PIPE_MULT_EN
      end else if (load_mul) begin
         vld_p1  <= 1'b1;
         res_p1  <= acc_p0;
         addr_p1 <= addr_p0;
         pc_p1   <= pc_p0;
         off_p1  <= off_p0;
         zero_p1 <= (acc_p0 == '0);
         tb_p1   <= br_p0 && (acc_p0 == '0);
`endif
      end else if (bus.out_ready) begin
         vld_p1  <= 1'b0;
      end
   end

   assign bus.in_ready    = in_ready_c;
   assign bus.busy        = busy_c;
   assign bus.out_valid   = vld_p1;
   assign bus.resultOut   = res_p1;
   assign bus.address     = addr_p1;
   assign bus.pcout       = pc_p1;
   assign bus.offset      = off_p1;
   assign bus.zero        = zero_p1;
   assign bus.take_branch = tb_p1;

endmodule

// File: tb/tb_ex_pipe.sv
// tb_ex_pipe: directed and randomized checks of ex_pipe against a
// behavioural model. Handles builds with or without EX_PIPE_MULT_EN.
module tb_ex_pipe;
   localparam int XLEN = 32;
`ifdef EX_PIPE_MULT_EN
   localparam int EXP_BUSY  = 32;
   localparam int EXP_FIRST = 33;
`else
   localparam int EXP_BUSY  = 0;
   localparam int EXP_FIRST = 0;
`endif

   logic clk = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   ex_pipe_if #(.XLEN(XLEN)) bus();
   ex_pipe #(.XLEN(XLEN)) dut (.clk(clk), .reset(reset), .bus(bus));

   int total = 0;
   int bad = 0;

   logic [31:0] e_res, e_off, e_addr, e_pc;
   logic        e_zero, e_tb;
   logic [31:0] h_res, h_addr, h_pc;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Behavioural result: plain arithmetic on 64-bit values, truncated to 32.
   function automatic logic [31:0] model_res(input logic [31:0] a, input logic [31:0] rt,
                                             input logic [31:0] sx, input logic src,
                                             input logic [1:0] op, input logic [5:0] fn);
      logic [31:0] b;
      longint sa, sb;
      b  = src ? sx : rt;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      case (op)
         2'b00: return 32'(sa + sb);
         2'b01: return 32'(sa - sb);
         2'b11: return (sa < sb) ? 32'd1 : 32'd0;
         default: begin
            case (fn)
               6'h20: return 32'(sa + sb);
               6'h22: return 32'(sa - sb);
               6'h24: return a & b;
               6'h25: return a | b;
               6'h2a: return (sa < sb) ? 32'd1 : 32'd0;
`ifdef EX_PIPE_MULT_EN
               6'h18: return 32'(64'(a) * 64'(b));
`endif
               default: return 32'd0;
            endcase
         end
      endcase
   endfunction

   task automatic drive(input logic [31:0] rs, input logic [31:0] rt, input logic [31:0] sx,
                        input logic [31:0] pc, input logic src, input logic [1:0] op,
                        input logic [5:0] fn, input logic br);
      bus.rs = rs; bus.rt = rt; bus.sign_ext = sx; bus.pc = pc;
      bus.ALUSrc = src; bus.ALUOp = op; bus.funct = fn; bus.branch = br;
      bus.in_valid = 1'b1;
      e_res  = model_res(rs, rt, sx, src, op, fn);
      e_off  = sx * 32'd4;
      e_addr = pc + e_off;
      e_pc   = pc;
      e_zero = (e_res == 32'd0);
      e_tb   = br && e_zero;
   endtask

   task automatic check_out(input string tag);
      chk({tag, ".vld"},  32'(bus.out_valid),   32'd1);
      chk({tag, ".res"},  bus.resultOut,        e_res);
      chk({tag, ".off"},  bus.offset,           e_off);
      chk({tag, ".addr"}, bus.address,          e_addr);
      chk({tag, ".pc"},   bus.pcout,            e_pc);
      chk({tag, ".zero"}, 32'(bus.zero),        32'(e_zero));
      chk({tag, ".tb"},   32'(bus.take_branch), 32'(e_tb));
   endtask

   task automatic drive_random();
      logic [31:0] a, b;
      logic [1:0]  op;
      logic [5:0]  fn_tab [6];
      fn_tab = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2a, 6'h3f};
      a  = $urandom;
      b  = ($urandom_range(0, 3) == 0) ? a : $urandom;
      op = 2'($urandom_range(0, 3));
      drive(a, b, $urandom, $urandom, 1'($urandom_range(0, 1)), op,
            fn_tab[$urandom_range(0, 5)], 1'($urandom_range(0, 1)));
   endtask

   // Accept one multiply, then watch 40 cycles for busy and the first valid result.
   task automatic run_mult(input logic [31:0] a, input logic [31:0] b, input string tag);
      int busy_n = 0;
      int ready_bad = 0;
      int first = -1;
      logic [31:0] got = 32'd0;
      @(negedge clk);
      drive(a, b, 32'd0, 32'h100, 1'b0, 2'b10, 6'h18, 1'b0);
      #1 chk({tag, ".rdy"}, 32'(bus.in_ready), 32'd1);
      @(posedge clk);
      #1 bus.in_valid = 1'b0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (bus.busy) busy_n++;
         if (bus.busy && bus.in_ready) ready_bad++;
         if (first < 0 && bus.out_valid) begin
            first = k;
            got = bus.resultOut;
         end
      end
      chk({tag, ".busy_cycles"}, 32'(busy_n), 32'(EXP_BUSY));
      chk({tag, ".first_valid"}, 32'(first), 32'(EXP_FIRST));
      chk({tag, ".ready_while_busy"}, 32'(ready_bad), 32'd0);
      chk({tag, ".res"}, got, e_res);
   endtask

   initial begin
      #200000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

   initial begin
      int vcount;
      bus.flush = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b1;
      bus.rs = '0; bus.rt = '0; bus.sign_ext = '0; bus.pc = '0;
      bus.ALUSrc = 1'b0; bus.ALUOp = 2'b00; bus.funct = 6'h0; bus.branch = 1'b0;

      // Reset state
      repeat (2) @(negedge clk);
      chk("rst.vld",  32'(bus.out_valid), 32'd0);
      chk("rst.busy", 32'(bus.busy), 32'd0);
      chk("rst.res",  bus.resultOut, 32'd0);
      chk("rst.addr", bus.address, 32'd0);
      chk("rst.pc",   bus.pcout, 32'd0);
      chk("rst.off",  bus.offset, 32'd0);
      chk("rst.zero", 32'(bus.zero), 32'd0);
      chk("rst.tb",   32'(bus.take_branch), 32'd0);
      reset = 1'b1;
      @(posedge clk);
      #1 chk("rst.rdy_after_release", 32'(bus.in_ready), 32'd1);

      // Subtract-to-zero branch example
      @(negedge clk);
      drive(32'd5, 32'd5, 32'd5, 32'd4, 1'b0, 2'b01, 6'h0, 1'b1);
      @(posedge clk); @(negedge clk);
      chk("br.vld",  32'(bus.out_valid), 32'd1);
      chk("br.res",  bus.resultOut, 32'd0);
      chk("br.zero", 32'(bus.zero), 32'd1);
      chk("br.tb",   32'(bus.take_branch), 32'd1);
      chk("br.off",  bus.offset, 32'd20);
      chk("br.addr", bus.address, 32'd24);
      chk("br.pc",   bus.pcout, 32'd4);

      // Signed slt both ways, back-to-back
      drive(32'hFFFF_FFFD, 32'd2, 32'd0, 32'h40, 1'b0, 2'b10, 6'h2a, 1'b0);
      @(posedge clk); @(negedge clk);
      chk("slt_neg.res", bus.resultOut, 32'd1);
      drive(32'd2, 32'hFFFF_FFFD, 32'd0, 32'h44, 1'b0, 2'b10, 6'h2a, 1'b0);
      @(posedge clk); @(negedge clk);
      chk("slt_pos.res", bus.resultOut, 32'd0);
      chk("slt_pos.vld", 32'(bus.out_valid), 32'd1);

      // Random back-to-back single-cycle ops
      for (int i = 0; i < 30; i++) begin
         drive_random();
         #1 chk("rand.rdy", 32'(bus.in_ready), 32'd1);
         @(posedge clk); @(negedge clk);
         check_out("rand");
      end
      bus.in_valid = 1'b0;
      @(posedge clk); @(negedge clk);
      chk("drain.vld", 32'(bus.out_valid), 32'd0);

      // Back-pressure: hold for 5 cycles with a pending input
      bus.out_ready = 1'b0;
      drive_random();
      @(posedge clk); @(negedge clk);
      check_out("bp_a");
      h_res = e_res; h_addr = e_addr; h_pc = e_pc;
      drive_random();
      for (int i = 0; i < 5; i++) begin
         #1 chk("bp.rdy", 32'(bus.in_ready), 32'd0);
         @(posedge clk); @(negedge clk);
         chk("bp.vld",  32'(bus.out_valid), 32'd1);
         chk("bp.res",  bus.resultOut, h_res);
         chk("bp.addr", bus.address, h_addr);
         chk("bp.pc",   bus.pcout, h_pc);
      end
      bus.out_ready = 1'b1;
      #1 chk("bp.rdy_release", 32'(bus.in_ready), 32'd1);
      @(posedge clk); @(negedge clk);
      check_out("bp_b");
      bus.in_valid = 1'b0;
      @(posedge clk); @(negedge clk);
      chk("bp.drain", 32'(bus.out_valid), 32'd0);

      // Flush beats simultaneous accept and drain
      bus.out_ready = 1'b0;
      drive_random();
      @(posedge clk); @(negedge clk);
      check_out("fl_c");
      drive_random();
      bus.flush = 1'b1; bus.out_ready = 1'b1;
      #1 chk("flush.rdy", 32'(bus.in_ready), 32'd0);
      @(posedge clk); @(negedge clk);
      chk("flush.vld", 32'(bus.out_valid), 32'd0);
      bus.flush = 1'b0; bus.in_valid = 1'b0;
      @(posedge clk); @(negedge clk);
      chk("flush.no_accept", 32'(bus.out_valid), 32'd0);

      // Asynchronous reset clears outputs before any clock edge
      drive_random();
      @(posedge clk); @(negedge clk);
      check_out("ar");
      bus.in_valid = 1'b0; bus.out_ready = 1'b0;
      #2 reset = 1'b0;
      #1;
      chk("ar.vld", 32'(bus.out_valid), 32'd0);
      chk("ar.res", bus.resultOut, 32'd0);
      chk("ar.addr", bus.address, 32'd0);
      chk("ar.off", bus.offset, 32'd0);
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1 chk("ar.rdy_after_release", 32'(bus.in_ready), 32'd1);
      bus.out_ready = 1'b1;

      // Multiply: directed and random signed operands
      run_mult(32'd7, 32'd6, "mul7x6");
      run_mult($urandom, 32'hFFFF_0000 | 32'($urandom_range(0, 65535)), "mulrnd");

      // Flush on cycle 10 of a multiply: no late result
      @(negedge clk);
      drive($urandom, $urandom, 32'd0, 32'h200, 1'b0, 2'b10, 6'h18, 1'b0);
      @(posedge clk);
      #1 bus.in_valid = 1'b0;
      repeat (10) @(negedge clk);
      bus.flush = 1'b1;
      @(posedge clk);
      #1 bus.flush = 1'b0;
      @(negedge clk);
      chk("mflush.busy", 32'(bus.busy), 32'd0);
      chk("mflush.vld",  32'(bus.out_valid), 32'd0);
      vcount = 0;
      repeat (40) begin
         @(negedge clk);
         if (bus.out_valid) vcount++;
      end
      chk("mflush.late_result", 32'(vcount), 32'd0);
      chk("mflush.rdy", 32'(bus.in_ready), 32'd1);

      // Reset in the middle of a multiply: abandoned
      @(negedge clk);
      drive($urandom, $urandom, 32'd0, 32'h300, 1'b0, 2'b10, 6'h18, 1'b0);
      @(posedge clk);
      #1 bus.in_valid = 1'b0;
      repeat (5) @(negedge clk);
      #1 reset = 1'b0;
      #1;
      chk("mrst.busy", 32'(bus.busy), 32'd0);
      chk("mrst.vld",  32'(bus.out_valid), 32'd0);
      @(negedge clk);
      reset = 1'b1;
      vcount = 0;
      repeat (40) begin
         @(negedge clk);
         if (bus.out_valid) vcount++;
      end
      chk("mrst.late_result", 32'(vcount), 32'd0);
      chk("mrst.rdy", 32'(bus.in_ready), 32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/ex_pipe.md
EX_PIPE -- requirements
Module: ex_pipe

Interface
REQ-001 Parameter XLEN, default 32: datapath width in bits for all operand/result ports.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset; asserted when 0.
REQ-004 flush  input  1  synchronous pipeline flush.
REQ-005 in_valid  input  1  upstream operands valid.
REQ-006 in_ready  output  1  stage can accept operands this cycle.
REQ-007 rs, rt, sign_ext, pc  input  XLEN each  register operands, sign-extended immediate, PC of instruction.
REQ-008 ALUSrc  input  1  operand B select: 1=sign_ext, 0=rt.
REQ-009 ALUOp  input  2  00=add, 01=sub, 10=R-type by funct, 11=slt.
REQ-010 funct  input  6  R-type function code.
REQ-011 branch  input  1  instruction is a conditional branch.
REQ-012 out_valid  output  1  registered result valid.
REQ-013 out_ready  input  1  downstream accepts result.
REQ-014 resultOut, address, pcout, offset  output  XLEN each  ALU result, branch target, forwarded PC, shifted offset.
REQ-015 zero, take_branch, busy  output  1 each  result-is-zero, branch taken, multi-cycle op in progress.

Function
REQ-016 Operand B SHALL be sign_ext when ALUSrc=1, else rt.
REQ-017 R-type funct SHALL decode: 100000 add, 100010 sub, 100100 and, 100101 or, 101010 signed slt, 011000 mult (low XLEN bits, REQ-031); any other funct SHALL yield result 0.
REQ-018 Add/sub SHALL wrap modulo 2^XLEN; slt SHALL give 1 or 0 zero-extended.
REQ-019 offset SHALL be sign_ext shifted left 2, truncated to XLEN; address SHALL be pc+offset modulo 2^XLEN; pcout SHALL equal the accepted pc.
REQ-020 zero SHALL be 1 iff resultOut==0; take_branch SHALL be branch AND zero of the same result.
REQ-021 Transfer in SHALL occur when in_valid AND in_ready; in_ready SHALL be (NOT out_valid OR out_ready) AND NOT busy AND NOT flush.
REQ-022 Single-cycle ops SHALL present all outputs registered, with out_valid=1, on the edge after acceptance (latency 1).
REQ-023 While out_valid=1 and out_ready=0, all outputs SHALL hold stable.
REQ-024 out_valid SHALL clear on the edge where out_ready=1 and no new transfer occurs; accept and drain in the same cycle SHALL load the new result back-to-back.
REQ-025 Control SHALL be an FSM: IDLE (accepting), MUL (iterating), DONE (load output register, return to IDLE).
REQ-026 flush=1 SHALL clear out_valid, force FSM to IDLE, deassert busy; flush SHALL take priority over simultaneous accept and drain.

Reset
REQ-027 reset=0 SHALL immediately force FSM IDLE, out_valid=0, busy=0, and resultOut, address, pcout, offset, zero, take_branch to 0.
REQ-028 reset asserted mid-multiply SHALL abandon the operation; no result SHALL be produced after release.
REQ-029 in_ready SHALL be 1 on the first edge after reset release when flush=0.

Configuration
REQ-030 Macro EX_PIPE_MULT_EN SHALL compile the multiplier in or out.
REQ-031 Defined: mult SHALL use an iterative shift-add unit, busy=1 for exactly XLEN cycles, out_valid rising XLEN+1 cycles after acceptance, in_ready=0 throughout.
REQ-032 Undefined: funct 011000 SHALL be an unknown funct (result 0, latency 1); busy SHALL be tied 0 and the MUL state SHALL not exist.

Verification
REQ-033 rs=5, rt=5, pc=4, sign_ext=5, ALUSrc=0, ALUOp=01, branch=1 -> next cycle resultOut=0, zero=1, take_branch=1, offset=20, address=24, pcout=4.
REQ-034 ALUOp=10, funct=101010, rs=-3, rt=2, ALUSrc=0 -> resultOut=1; rs=2, rt=-3 -> resultOut=0.
REQ-035 Result held with out_ready=0 for 5 cycles, in_valid=1 -> in_ready=0, outputs stable; out_ready=1 -> pending input accepted, new result next cycle.
REQ-036 With EX_PIPE_MULT_EN, XLEN=32, rs=7, rt=6, funct=011000 -> busy 32 cycles, out_valid on cycle 33, resultOut=42; without macro -> resultOut=0 on cycle 1.
REQ-037 flush at cycle 10 of a multiply, or reset=0 mid-multiply -> out_valid=0, busy=0, FSM IDLE, no late result.
